// File: rtl/dac_fade_out.sv
// dac_fade_out: gain-ramped output stage in front of an offset-binary DAC.
//   Fades the sample stream in after a mode change out of silence, fades it
//   out on any later mode change, and mutes to midscale when the mode is 0.
//   It also counts full-scale (clipped) input samples.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   i_mode[31:0]      - output mode word, only [7:0] is used
//   i_dac_data        - signed 16-bit sample
//   i_valid           - one-cycle strobe per sample
//   i_clr             - clears the clip counter
//   o_dac_code        - offset-binary code, held between updates
//   o_dac_valid       - one-cycle pulse, 2 cycles after i_valid
//   o_muted           - high while the FSM is in MUTE
//   o_clip_cnt        - saturating count of full-scale samples
module dac_fade_out #(
  parameter int DAC_W      = 14,
  parameter int RAMP_SHIFT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        i_mode,
  input  logic signed [15:0] i_dac_data,
  input  logic               i_valid,
  input  logic               i_clr,
  output logic [DAC_W-1:0]   o_dac_code,
  output logic               o_dac_valid,
  output logic               o_muted,
  output logic [15:0]        o_clip_cnt
);

  localparam int GW = RAMP_SHIFT + 1;       // gain spans 0..2^RAMP_SHIFT
  localparam int PW = 16 + RAMP_SHIFT + 2;  // signed product width
  localparam logic [GW-1:0]    G_FULL = {1'b1, {RAMP_SHIFT{1'b0}}};
  localparam logic [DAC_W-1:0] MID    = {1'b1, {(DAC_W-1){1'b0}}};

  typedef enum logic [1:0] {S_MUTE, S_FADE_IN, S_RUN, S_FADE_OUT} state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         g_q, g_d;
  logic [7:0]            m_q, m_d;
  logic signed [PW-1:0]  p_q, p_d;
  logic                  v1_q, v1_d;
  logic [DAC_W-1:0]      code_q, code_d;
  logic                  dval_q, dval_d;
  logic                  muted_q, muted_d;
  logic [15:0]           clip_q, clip_d;

  logic                  mode_chg;
  logic                  clip_hit;
  logic signed [PW-1:0]  a_ext, g_ext, shifted;
  logic signed [15:0]    s;

  // FSM next-state and gain; both move only on valid samples
  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    m_d      = m_q;
    mode_chg = (i_mode[7:0] != m_q);
    if (i_valid) begin
      case (state_q)
        S_MUTE: begin
          if (mode_chg) begin
            m_d = i_mode[7:0];
            if (i_mode[7:0] != 8'd0) state_d = S_FADE_IN;
          end
        end
        S_FADE_IN: begin
          // A mode change mid-ramp reverses from the current gain
          if (mode_chg) state_d = S_FADE_OUT;
          else begin
            g_d = g_q + 1'b1;
            if (g_d == G_FULL) state_d = S_RUN;
          end
        end
        S_RUN: begin
          g_d = G_FULL;
          if (mode_chg) state_d = S_FADE_OUT;
        end
        S_FADE_OUT: begin
          // Gain can already be 0 if the fade-in was aborted at its start
          if (g_q == '0) state_d = S_MUTE;
          else begin
            g_d = g_q - 1'b1;
            if (g_d == '0) state_d = S_MUTE;
          end
        end
        default: state_d = S_MUTE;
      endcase
    end
  end

  // Datapath: scale by pre-update gain, then shift back and re-bias
  always_comb begin
    a_ext    = PW'(i_dac_data);
    g_ext    = PW'({1'b0, g_q});
    p_d      = i_valid ? (a_ext * g_ext) : p_q;
    v1_d     = i_valid;
    shifted  = p_q >>> RAMP_SHIFT;
    s        = shifted[15:0];
    code_d   = v1_q ? (s[15 -: DAC_W] ^ MID) : code_q;
    dval_d   = v1_q;
    muted_d  = (state_d == S_MUTE);
    clip_hit = i_valid && ((i_dac_data == 16'sh7FFF) || (i_dac_data == 16'sh8000));
    clip_d   = clip_q;
    if (i_clr)                                clip_d = 16'd0;
    else if (clip_hit && clip_q != 16'hFFFF)  clip_d = clip_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_MUTE;
      g_q     <= '0;
      m_q     <= '0;
      p_q     <= '0;
      v1_q    <= 1'b0;
      code_q  <= MID;
      dval_q  <= 1'b0;
      muted_q <= 1'b1;
      clip_q  <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      m_q     <= m_d;
      p_q     <= p_d;
      v1_q    <= v1_d;
      code_q  <= code_d;
      dval_q  <= dval_d;
      muted_q <= muted_d;
      clip_q  <= clip_d;
    end
  end

  assign o_dac_code  = code_q;
  assign o_dac_valid = dval_q;
  assign o_muted     = muted_q;
  assign o_clip_cnt  = clip_q;

  // Upper mode bits and the low/high product bits are intentionally dropped
  logic unused_bits;
  assign unused_bits = ^{i_mode[31:8], shifted};

endmodule

// File: tb/tb_dac_fade_out.sv
module tb_dac_fade_out;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [31:0]        mode = '0;
  logic signed [15:0] data = '0;
  logic               valid = 1'b0;
  logic               clr = 1'b0;
  logic [13:0]        code;
  logic               dval;
  logic               muted;
  logic [15:0]        clip;

  int n_vec = 0;
  int n_err = 0;

  dac_fade_out #(.DAC_W(14), .RAMP_SHIFT(8)) dut (
    .clk(clk), .rst(rst), .i_mode(mode), .i_dac_data(data), .i_valid(valid),
    .i_clr(clr), .o_dac_code(code), .o_dac_valid(dval), .o_muted(muted),
    .o_clip_cnt(clip)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Code for data 0x4000 at gain g: (0x4000*g/256)>>2 = 16*g, plus midscale
  function automatic logic [13:0] c4k(input int g);
    return 14'(8192 + 16 * g);
  endfunction

  task automatic test_reset();
    rst = 1; valid = 1; clr = 1; data = 16'sh7FFF; mode = 2;
    repeat (3) tick();
    n_vec++; if (code !== 14'd8192) begin n_err++; $display("FAIL reset_code got %0h exp %0h", code, 14'd8192); end
    n_vec++; if (dval !== 1'b0) begin n_err++; $display("FAIL reset_dval got %0b exp 0", dval); end
    n_vec++; if (muted !== 1'b1) begin n_err++; $display("FAIL reset_muted got %0b exp 1", muted); end
    n_vec++; if (clip !== 16'd0) begin n_err++; $display("FAIL reset_clip got %0h exp 0", clip); end
    rst = 0; valid = 0; clr = 0; mode = 0; data = 0;
    tick();
  endtask

  task automatic test_mode_zero();
    mode = 0; data = 16'sh4000; valid = 1;
    for (int n = 0; n < 6; n++) begin
      tick();
      n_vec++; if (muted !== 1'b1) begin n_err++; $display("FAIL mode0_muted n=%0d got %0b exp 1", n, muted); end
      if (n >= 1) begin
        n_vec++; if (dval !== 1'b1 || code !== 14'd8192) begin n_err++; $display("FAIL mode0_out n=%0d got %0b/%0h exp 1/2000", n, dval, code); end
      end
    end
    valid = 0; tick(); tick();
  endtask

  task automatic test_fade_in();
    int k, ge;
    mode = 2; data = 16'sh4000; valid = 1;
    for (int n = 0; n <= 260; n++) begin
      tick();
      if (n == 0) begin
        n_vec++; if (muted !== 1'b0) begin n_err++; $display("FAIL fadein_muted got %0b exp 0", muted); end
      end
      if (n >= 1) begin
        k  = n - 1;
        ge = (k == 0) ? 0 : ((k - 1 > 256) ? 256 : k - 1);
        n_vec++; if (dval !== 1'b1 || code !== c4k(ge)) begin n_err++; $display("FAIL fadein_code k=%0d got %0b/%0h exp 1/%0h", k, dval, code, c4k(ge)); end
        if (k == 129) begin
          n_vec++; if (code !== 14'h2800) begin n_err++; $display("FAIL fadein_g128 got %0h exp 2800", code); end
        end
      end
    end
    valid = 0; tick();
    n_vec++; if (dval !== 1'b1 || code !== 14'h3000) begin n_err++; $display("FAIL run_code got %0b/%0h exp 1/3000", dval, code); end
    tick();
    n_vec++; if (dval !== 1'b0 || code !== 14'h3000) begin n_err++; $display("FAIL hold_code got %0b/%0h exp 0/3000", dval, code); end
  endtask

  task automatic test_clip_run();
    clr = 1; tick(); clr = 0;
    n_vec++; if (clip !== 16'd0) begin n_err++; $display("FAIL clr got %0h exp 0", clip); end
    data = 16'sh7FFF; valid = 1; tick();
    n_vec++; if (clip !== 16'd1) begin n_err++; $display("FAIL clip_pos got %0h exp 1", clip); end
    data = 16'sh8000; tick();
    n_vec++; if (code !== 14'h3FFF) begin n_err++; $display("FAIL code_pos_fs got %0h exp 3fff", code); end
    n_vec++; if (clip !== 16'd2) begin n_err++; $display("FAIL clip_neg got %0h exp 2", clip); end
    valid = 0; tick();
    n_vec++; if (dval !== 1'b1 || code !== 14'h0000) begin n_err++; $display("FAIL code_neg_fs got %0b/%0h exp 1/0", dval, code); end
    tick();
    n_vec++; if (dval !== 1'b0 || code !== 14'h0000) begin n_err++; $display("FAIL code_neg_hold got %0b/%0h exp 0/0", dval, code); end
  endtask

  task automatic test_fade_out();
    int k, ge;
    mode = 4; data = 16'sh4000; valid = 1;
    for (int n = 0; n <= 259; n++) begin
      tick();
      n_vec++; if (muted !== (n == 256)) begin n_err++; $display("FAIL fadeout_muted n=%0d got %0b exp %0b", n, muted, (n == 256)); end
      if (n >= 1) begin
        k  = n - 1;
        ge = (k == 0) ? 256 : ((k <= 256) ? 257 - k : 0);
        n_vec++; if (dval !== 1'b1 || code !== c4k(ge)) begin n_err++; $display("FAIL fadeout_code k=%0d got %0b/%0h exp 1/%0h", k, dval, code, c4k(ge)); end
      end
    end
    valid = 0; tick(); tick();
  endtask

  task automatic test_abort_fade_in();
    int k, ge;
    rst = 1; tick(); rst = 0;
    mode = 2; data = 16'sh4000; valid = 1;
    for (int n = 0; n <= 203; n++) begin
      if (n == 101) mode = 5;
      if (n == 150) mode = 7;  // ignored while fading out
      tick();
      n_vec++; if (muted !== (n == 201)) begin n_err++; $display("FAIL abort_muted n=%0d got %0b exp %0b", n, muted, (n == 201)); end
      if (n >= 1) begin
        k = n - 1;
        if (k == 0)        ge = 0;
        else if (k <= 100) ge = k - 1;
        else if (k == 101) ge = 100;
        else if (k <= 201) ge = 202 - k;
        else               ge = 0;
        n_vec++; if (dval !== 1'b1 || code !== c4k(ge)) begin n_err++; $display("FAIL abort_code k=%0d got %0b/%0h exp 1/%0h", k, dval, code, c4k(ge)); end
      end
    end
  endtask

  task automatic test_reset_mid_ramp();
    // Still fading in from the previous scenario, valid held high
    repeat (20) tick();
    rst = 1;
    for (int n = 0; n < 3; n++) begin
      tick();
      n_vec++; if (dval !== 1'b0 || muted !== 1'b1 || code !== 14'd8192) begin n_err++; $display("FAIL midrst n=%0d got %0b/%0b/%0h exp 0/1/2000", n, dval, muted, code); end
    end
    rst = 0; mode = 5;
    tick();
    n_vec++; if (dval !== 1'b0 || muted !== 1'b0) begin n_err++; $display("FAIL midrst_rel got %0b/%0b exp 0/0", dval, muted); end
    tick();
    n_vec++; if (dval !== 1'b1 || code !== c4k(0)) begin n_err++; $display("FAIL midrst_s0 got %0b/%0h exp 1/%0h", dval, code, c4k(0)); end
    tick();
    n_vec++; if (dval !== 1'b1 || code !== c4k(0)) begin n_err++; $display("FAIL midrst_s1 got %0b/%0h exp 1/%0h", dval, code, c4k(0)); end
    tick();
    n_vec++; if (dval !== 1'b1 || code !== c4k(1)) begin n_err++; $display("FAIL midrst_s2 got %0b/%0h exp 1/%0h", dval, code, c4k(1)); end
    valid = 0; tick(); tick();
  endtask

  task automatic test_gapped();
    logic [13:0] exp_code;
    logic        exp_v;
    int          k, ge;
    rst = 1; tick(); rst = 0;
    mode = 3; data = 16'sh4000;
    exp_code = 14'd8192;
    for (int c = 0; c < 30; c++) begin
      valid = (c % 5 == 0);
      tick();
      exp_v = (c >= 1) && ((c - 1) % 5 == 0);
      if (exp_v) begin
        k  = (c - 1) / 5;
        ge = (k == 0) ? 0 : k - 1;
        exp_code = c4k(ge);
      end
      n_vec++; if (dval !== exp_v || code !== exp_code) begin n_err++; $display("FAIL gapped c=%0d got %0b/%0h exp %0b/%0h", c, dval, code, exp_v, exp_code); end
    end
    valid = 0; tick();
  endtask

  task automatic test_clip_sat();
    clr = 1; tick(); clr = 0;
    data = 16'sh8000; valid = 1;
    repeat (65535) tick();
    n_vec++; if (clip !== 16'hFFFF) begin n_err++; $display("FAIL sat_reach got %0h exp ffff", clip); end
    repeat (3) tick();
    n_vec++; if (clip !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold got %0h exp ffff", clip); end
    data = 16'sh7FFE; tick();
    n_vec++; if (clip !== 16'hFFFF) begin n_err++; $display("FAIL nonclip got %0h exp ffff", clip); end
    clr = 1; data = 16'sh7FFF; tick();
    n_vec++; if (clip !== 16'd0) begin n_err++; $display("FAIL clr_wins got %0h exp 0", clip); end
    clr = 0; tick();
    n_vec++; if (clip !== 16'd1) begin n_err++; $display("FAIL clip_after_clr got %0h exp 1", clip); end
    valid = 0; tick();
  endtask

  initial begin
    test_reset();
    test_mode_zero();
    test_fade_in();
    test_clip_run();
    test_fade_out();
    test_abort_fade_in();
    test_reset_mid_ramp();
    test_gapped();
    test_clip_sat();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
